// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory, decode and redirect signals of the fetch stage
interface inst_fetch_unit_if;
   // instruction memory side
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   // decode side
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        inst_ready;
   // redirect inputs from control_unit / ALU / register file
   logic        b_beq;
   logic        beq_zero;
   logic        b_jal;
   logic        b_jalr;
   logic [31:0] imm;
   logic [31:0] rs1_val;

   // fetch unit side
   modport master (
      output imem_req, imem_addr, inst, pc, inst_valid,
      input  imem_ready, imem_rvalid, imem_rdata, inst_ready,
      input  b_beq, beq_zero, b_jal, b_jalr, imm, rs1_val
   );

   // memory + decode side
   modport slave (
      input  imem_req, imem_addr, inst, pc, inst_valid,
      output imem_ready, imem_rvalid, imem_rdata, inst_ready,
      output b_beq, beq_zero, b_jal, b_jalr, imm, rs1_val
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC holder and single-outstanding instruction fetch FSM (option: INST_FETCH_MISALIGN_CHECK_EN)
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   inst_fetch_unit_if.master bus
`ifdef INST_FETCH_MISALIGN_CHECK_EN
   ,
   output logic              fetch_misaligned
`endif
);

`ifdef INST_FETCH_MISALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;
`endif

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        inst_valid_q;
   logic        imem_req_q;
   logic [31:0] next_pc;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
   logic        misaligned_q;
`endif

   // Redirect target; only meaningful in the decode handshake cycle, jalr > jal > taken beq > sequential
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (bus.b_jalr) begin
         next_pc = (bus.rs1_val + bus.imm) & ~32'h1;
      end else if (bus.b_jal || (bus.b_beq && bus.beq_zero)) begin
         next_pc = pc_q + bus.imm;
      end
   end

   // Fetch FSM with registered request, instruction and valid outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_valid_q <= 1'b0;
         imem_req_q   <= 1'b0;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q    <= S_REQ;
               imem_req_q <= 1'b1;
            end
            S_REQ: begin
               // request and address stay put until memory takes them
               if (bus.imem_ready) begin
                  state_q    <= S_WAIT;
                  imem_req_q <= 1'b0;
               end
            end
            S_WAIT: begin
               // responses are only accepted here, so stray rvalid elsewhere is dropped
               if (bus.imem_rvalid) begin
                  state_q      <= S_VALID;
                  inst_q       <= bus.imem_rdata;
                  inst_valid_q <= 1'b1;
               end
            end
            S_VALID: begin
               if (bus.inst_ready) begin
                  pc_q         <= next_pc;
                  inst_q       <= NOP_INST;
                  inst_valid_q <= 1'b0;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
                  if (next_pc[1:0] != 2'b00) begin
                     // misaligned target: park forever without touching memory
                     misaligned_q <= 1'b1;
                     state_q      <= S_HALT;
                     imem_req_q   <= 1'b0;
                  end else begin
                     state_q    <= S_REQ;
                     imem_req_q <= 1'b1;
                  end
`else
                  state_q    <= S_REQ;
                  imem_req_q <= 1'b1;
`endif
               end
            end
`ifdef INST_FETCH_MISALIGN_CHECK_EN
            S_HALT: begin
               state_q    <= S_HALT;
               imem_req_q <= 1'b0;
            end
`endif
            default: begin
               state_q    <= S_IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = pc_q;
   assign bus.pc         = pc_q;
   assign bus.inst       = inst_q;
   assign bus.inst_valid = inst_valid_q;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
   assign fetch_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_valid_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inst_fetch_unit_if bus ();

`ifdef INST_FETCH_MISALIGN_CHECK_EN
   logic fetch_misaligned;
`endif

   inst_fetch_unit #(
      .RESET_PC(32'h0000_0000),
      .NOP_INST(NOP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef INST_FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned(fetch_misaligned)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_redirect();
      bus.b_beq    = 1'b0;
      bus.beq_zero = 1'b0;
      bus.b_jal    = 1'b0;
      bus.b_jalr   = 1'b0;
      bus.imm      = 32'h0;
      bus.rs1_val  = 32'h0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                           input int rdy_w, input int rv_w, input int dec_w,
                           input logic jalr, input logic jal, input logic beq, input logic zero,
                           input logic [31:0] immv, input logic [31:0] rs1v, input bit chk_tp);
      wait_req();
      chk("req_asserted", {31'b0, bus.imem_req}, 32'd1);
      chk("req_addr", bus.imem_addr, exp_addr);
      for (int i = 0; i < rdy_w; i++) begin
         @(negedge clk);
         chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
         chk("addr_hold", bus.imem_addr, exp_addr);
      end
      bus.imem_ready = 1'b1;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      chk("no_second_req", {31'b0, bus.imem_req}, 32'd0);
      for (int i = 0; i < rv_w; i++) begin
         @(negedge clk);
         chk("wait_no_req", {31'b0, bus.imem_req}, 32'd0);
         chk("wait_no_valid", {31'b0, bus.inst_valid}, 32'd0);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      chk("inst_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("inst_data", bus.inst, data);
      chk("inst_pc", bus.pc, exp_addr);
      if (chk_tp) chk("throughput", cyc - last_valid_cyc, 32'd3);
      last_valid_cyc = cyc;
      for (int i = 0; i < dec_w; i++) begin
         bus.b_jal  = 1'b1;
         bus.b_jalr = 1'b1;
         bus.imm    = 32'h0000_0100;
         @(negedge clk);
         chk("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
         chk("stall_inst", bus.inst, data);
         chk("stall_pc", bus.pc, exp_addr);
         chk("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
      end
      clear_redirect();
      bus.inst_ready = 1'b1;
      bus.b_jalr     = jalr;
      bus.b_jal      = jal;
      bus.b_beq      = beq;
      bus.beq_zero   = zero;
      bus.imm        = immv;
      bus.rs1_val    = rs1v;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      clear_redirect();
      chk("consumed_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("consumed_inst", bus.inst, NOP);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.inst_ready  = 1'b0;
      clear_redirect();
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rst_inst", bus.inst, NOP);
      chk("rst_pc", bus.pc, 32'h0);
`ifdef INST_FETCH_MISALIGN_CHECK_EN
      chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif
      rst_n = 1'b1;
      chk("idle_no_req", {31'b0, bus.imem_req}, 32'd0);

      // sequential zero-wait fetches
      do_fetch(32'h0000_0000, 32'h1111_0001, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
      do_fetch(32'h0000_0004, 32'h2222_0002, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1);
      // jal +0x10 from 0x8
      do_fetch(32'h0000_0008, 32'h3333_0003, 0, 0, 0, 0, 1, 0, 0, 32'h10, 32'h0, 1'b1);
      // beq not taken from 0x18
      do_fetch(32'h0000_0018, 32'h4444_0004, 0, 0, 0, 0, 0, 1, 0, 32'h40, 32'h0, 1'b1);
      // beq taken from 0x1C with imm=-12
      do_fetch(32'h0000_001C, 32'h5555_0005, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFF4, 32'h0, 1'b1);
      // jalr wins over jal and taken beq; LSB cleared: 0x101+0x20 -> 0x120
      do_fetch(32'h0000_0010, 32'h6666_0006, 0, 0, 0, 1, 1, 1, 1, 32'h20, 32'h101, 1'b1);
      // memory and decode back-pressure
      do_fetch(32'h0000_0120, 32'h7777_0007, 4, 3, 5, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
      // jalr to top of address space, then wrap to 0
      do_fetch(32'h0000_0124, 32'h8888_0008, 0, 0, 0, 1, 0, 0, 0, 32'hC, 32'hFFFF_FFF0, 1'b0);
      do_fetch(32'hFFFF_FFFC, 32'h9999_0009, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
      do_fetch(32'h0000_0000, 32'hAAAA_000A, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);

      // reset while waiting for the response of the fetch at 0x4
      wait_req();
      chk("pre_rst_addr", bus.imem_addr, 32'h4);
      bus.imem_ready = 1'b1;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("midrst_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("midrst_inst", bus.inst, NOP);
      chk("midrst_pc", bus.pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBADB_AD00;
      @(negedge clk);
      @(negedge clk);
      chk("stray_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("stray_inst", bus.inst, NOP);
      chk("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
      chk("post_rst_addr", bus.imem_addr, 32'h0);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;

      // jal +6 from 0x0 gives a misaligned target
      do_fetch(32'h0000_0000, 32'hBBBB_000B, 0, 0, 0, 0, 1, 0, 0, 32'h6, 32'h0, 1'b0);
`ifdef INST_FETCH_MISALIGN_CHECK_EN
      chk("misaligned_flag", {31'b0, fetch_misaligned}, 32'd1);
      chk("misaligned_pc", bus.pc, 32'h6);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("halt_no_req", {31'b0, bus.imem_req}, 32'd0);
      end
      chk("misaligned_sticky", {31'b0, fetch_misaligned}, 32'd1);
`else
      wait_req();
      chk("misaligned_req", {31'b0, bus.imem_req}, 32'd1);
      chk("misaligned_addr", bus.imem_addr, 32'h6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
